// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 encodings for the burst RAM slave: cycle type, burst extension and FSM states.
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_BEAT = 2'b10
  } state_e;

endpackage

// File: rtl/wb_ram_bytelane.sv
// One byte lane of the RAM: synchronous read, write-first when the write hits the word being read.
module wb_ram_bytelane #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    q
);

  logic [7:0] mem [DEPTH];

  // storage write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read port with write-first bypass
  always_ff @(posedge clk) begin
    if (we && (waddr == raddr)) begin
      q <= wdata;
    end else begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/wb_b3_ram_burst.sv
// Wishbone B3 RAM slave with classic and registered-feedback bursts, byte lanes and programmable first-access latency.
module wb_b3_ram_burst
  import wb_b3_pkg::*;
#(
  parameter int    DW          = 32,
  parameter int    AW          = 32,
  parameter int    MEM_BYTES   = 32'h8000,
  parameter int    MEM_AW      = 15,
  parameter int    WAIT_STATES = 0,
  parameter string MEM_FILE    = "sram.vmem"
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int SW    = DW / 8;
  localparam int SWB   = $clog2(SW);
  localparam int WA    = MEM_AW - SWB;
  localparam int WORDS = MEM_BYTES / SW;
  localparam logic [3:0]    WS  = 4'(WAIT_STATES);
  localparam logic [WA-1:0] ONE = {{(WA-1){1'b0}}, 1'b1};

  state_e        state_r, state_nxt;
  logic [3:0]    cnt_r;
  logic [WA-1:0] adr_r, nxt_adr, adv_adr, adr_in;
  logic [2:0]    cti_r;
  logic [1:0]    bte_r;
  logic [DW-1:0] rd_word;
  logic          req, range_err, bad, last, beat, ack, err, wr_en;
  logic          unused_adr_bits;

  assign req       = wb_cyc_i & wb_stb_i;
  assign adr_in    = wb_adr_i[MEM_AW-1:SWB];
  // the top address nibble is a region decode owned by the interconnect
  assign range_err = |wb_adr_i[AW-5:MEM_AW];
  assign bad       = range_err | (adr_in != adr_r);
  assign last      = !((cti_r == CTI_CONST) || (cti_r == CTI_INCR)) ||
                     (wb_cti_i == CTI_END) || (wb_cti_i == CTI_CLASSIC);
  assign unused_adr_bits = ^{wb_adr_i[AW-1:AW-4], wb_adr_i[SWB-1:0]};
  assign wb_rty_o  = 1'b0;

  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // wait counter, burst address and latched burst attributes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_r <= 4'd0;
      adr_r <= {WA{1'b0}};
      cti_r <= CTI_CLASSIC;
      bte_r <= BTE_LINEAR;
    end else begin
      adr_r <= nxt_adr;
      if ((state_r == ST_IDLE) && req) begin
        cnt_r <= WS;
        cti_r <= wb_cti_i;
        bte_r <= wb_bte_i;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) state_nxt = (WS == 4'd0) ? ST_BEAT : ST_WAIT;
        else     state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (!req)                state_nxt = ST_IDLE;
        else if (cnt_r <= 4'd1)  state_nxt = ST_BEAT;
        else                     state_nxt = ST_WAIT;
      end
      ST_BEAT: begin
        if (!wb_cyc_i)           state_nxt = ST_IDLE;
        else if (!wb_stb_i)      state_nxt = ST_BEAT;
        else if (bad || last)    state_nxt = ST_IDLE;
        else                     state_nxt = ST_BEAT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // burst address generator; wrap modes only roll the low word-address bits
  always_comb begin
    adv_adr = adr_r + ONE;
    case (bte_r)
      BTE_WRAP4:  adv_adr = {adr_r[WA-1:2], adr_r[1:0] + 2'd1};
      BTE_WRAP8:  adv_adr = {adr_r[WA-1:3], adr_r[2:0] + 3'd1};
      BTE_WRAP16: adv_adr = {adr_r[WA-1:4], adr_r[3:0] + 4'd1};
      default:    adv_adr = adr_r + ONE;
    endcase
  end

  // RAM read address is the address of the next cycle, so data lines up with ack
  always_comb begin
    nxt_adr = adr_r;
    if ((state_r == ST_IDLE) && req) begin
      nxt_adr = adr_in;
    end else if (ack && (cti_r == CTI_INCR)) begin
      nxt_adr = adv_adr;
    end else begin
      nxt_adr = adr_r;
    end
  end

  // bus outputs
  always_comb begin
    beat     = (state_r == ST_BEAT) && req;
    ack      = beat && !bad;
    err      = beat && bad;
    wr_en    = ack && wb_we_i;
    wb_ack_o = ack;
    wb_err_o = err;
    if (ack) wb_dat_o = rd_word;
    else     wb_dat_o = {DW{1'b0}};
  end

  for (genvar l = 0; l < SW; l++) begin : gen_lane
    wb_ram_bytelane #(.DEPTH(WORDS), .AW(WA)) u_lane (
      .clk   (wb_clk_i),
      .we    (wr_en & wb_sel_i[l]),
      .waddr (adr_r),
      .wdata (wb_dat_i[8*l +: 8]),
      .raddr (nxt_adr),
      .q     (rd_word[8*l +: 8])
    );
  end

endmodule
